// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the instruction-cache refill engine.
// Refill FSM state encodings, AXI burst/response/size constants and a width helper.
package icache_refill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_DONE = 3'd3,
    ST_COOL = 3'd4
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_4B        = 3'b010;

  // Width of a word-slot index; never zero so single-word lines still elaborate.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/icache_line_asm.sv
// Cacheline assembly register: one 32-bit slot per word, written at
// slot (start_word + cnt) mod WORDS so the line always lands in natural order.
module icache_line_asm
  import icache_refill_pkg::*;
#(
  parameter int CACHELINE_WD = 512,
  parameter int IDX_W        = idx_width(CACHELINE_WD / 32)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        start_word,
  input  logic [IDX_W-1:0]        cnt,
  input  logic [31:0]             wdata,
  output logic [CACHELINE_WD-1:0] line_data
);

  localparam int WORDS = CACHELINE_WD / 32;

  logic [IDX_W:0]   slot_sum;
  logic [IDX_W-1:0] slot_idx;

  // Explicit modular wrap keeps non-power-of-two word counts correct.
  always_comb begin
    slot_sum = {1'b0, start_word} + {1'b0, cnt};
    if (slot_sum >= (IDX_W+1)'(WORDS)) begin
      slot_idx = IDX_W'(slot_sum - (IDX_W+1)'(WORDS));
    end else begin
      slot_idx = slot_sum[IDX_W-1:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [31:0] word_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          word_reg <= '0;
        end else if (wr_en && (slot_idx == IDX_W'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign line_data[gi*32 +: 32] = word_reg;
    end
  endgenerate

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: one AXI4 read burst per miss, line returned with a refresh pulse.
// Optional macro ICACHE_CRITICAL_WORD_FIRST_EN: WRAP burst starting at the missed word.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int         CACHELINE_WD = 512,
  parameter logic [3:0] AXI_ID       = 4'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    icache_miss,
  input  logic [31:0]             icache_raddr,
  output logic                    icache_refresh,
  output logic [CACHELINE_WD-1:0] icache_cacheline_new,
  output logic                    refill_err,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int         WORDS      = CACHELINE_WD / 32;
  localparam int         IDX_W      = idx_width(WORDS);
  localparam logic [7:0] ARLEN_FULL = 8'(WORDS - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      araddr_reg;
  logic [7:0]       arlen_reg;
  logic             err_reg;
  logic             beat_fire;
  logic             capture;
  logic [31:0]      aligned_addr;
  logic [IDX_W-1:0] start_word;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] start_word_reg;

  assign aligned_addr = {icache_raddr[31:2], 2'b00};
  assign start_word   = start_word_reg;
  assign arburst      = AXI_BURST_WRAP;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_word_reg <= '0;
    end else if (capture) begin
      start_word_reg <= icache_raddr[IDX_W+1:2];
    end
  end
`else
  localparam int OFF_W = $clog2(CACHELINE_WD / 8);

  assign aligned_addr = (icache_raddr >> OFF_W) << OFF_W;
  assign start_word   = '0;
  assign arburst      = AXI_BURST_INCR;
`endif

  // Beat metadata plays no part in completion; the beat count alone ends the burst.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rlast};

  assign capture   = (state_reg == ST_IDLE) && icache_miss;
  assign beat_fire = (state_reg == ST_R) && rvalid;

  assign arid       = AXI_ID;
  assign arsize     = SIZE_4B;
  assign araddr     = araddr_reg;
  assign arlen      = arlen_reg;
  assign refill_err = err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      araddr_reg <= '0;
      arlen_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        araddr_reg <= aligned_addr;
        arlen_reg  <= ARLEN_FULL;
      end
      if (beat_fire && (rresp != AXI_RESP_OKAY)) begin
        err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    arvalid        = 1'b0;
    rready         = 1'b0;
    icache_refresh = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (icache_miss) begin
          state_next = ST_AR;
        end
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_next = ST_R;
          cnt_next   = '0;
        end
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid) begin
          cnt_next = cnt_reg + IDX_W'(1);
          if (cnt_reg == IDX_W'(WORDS - 1)) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        icache_refresh = 1'b1;
        state_next     = ST_COOL;
      end
      // One dead cycle so a still-asserted miss is not re-serviced during the tag update.
      ST_COOL: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  icache_line_asm #(
    .CACHELINE_WD (CACHELINE_WD),
    .IDX_W        (IDX_W)
  ) u_line_asm (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (beat_fire),
    .start_word (start_word),
    .cnt        (cnt_reg),
    .wdata      (rdata),
    .line_data  (icache_cacheline_new)
  );

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: table of refill scenarios against a small AXI slave model,
// expected lines queued at miss time and compared when the refresh pulse appears.
module tb_icache_refill;

  localparam int CL    = 512;
  localparam int WORDS = CL / 32;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam logic [1:0] EXP_BURST = 2'b10;
`else
  localparam logic [1:0] EXP_BURST = 2'b01;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_miss;
  logic [31:0]   icache_raddr;
  logic          icache_refresh;
  logic [CL-1:0] icache_cacheline_new;
  logic          refill_err;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  always #5 clk = ~clk;

  icache_refill #(
    .CACHELINE_WD (CL),
    .AXI_ID       (4'd0)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .icache_miss          (icache_miss),
    .icache_raddr         (icache_raddr),
    .icache_refresh       (icache_refresh),
    .icache_cacheline_new (icache_cacheline_new),
    .refill_err           (refill_err),
    .arid                 (arid),
    .araddr               (araddr),
    .arlen                (arlen),
    .arsize               (arsize),
    .arburst              (arburst),
    .arvalid              (arvalid),
    .arready              (arready),
    .rid                  (rid),
    .rdata                (rdata),
    .rresp                (rresp),
    .rlast                (rlast),
    .rvalid               (rvalid),
    .rready               (rready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    int          ar_stall;
    bit          gap;
    int          err_beat;
    int          rst_beat;
    bit          hold;
    logic [31:0] next_addr;
    int          exp_cyc;
  } vec_t;

  vec_t          vecs [8];
  logic [CL-1:0] sb_q [$];
  int            checks = 0;
  int            passed = 0;
  bit            err_exp = 1'b0;

  task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_araddr(input logic [31:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return {a[31:2], 2'b00};
`else
    return {a[31:6], 6'd0};
`endif
  endfunction

  function automatic int start_of(input logic [31:0] a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return int'(a[5:2]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [CL-1:0] exp_line(input logic [31:0] base);
    logic [CL-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Called right after a negedge; returns right after a negedge.
  task automatic run_refill(input int idx, input vec_t v);
    int  ar_left = v.ar_stall;
    int  beats = 0;
    int  first_r = -1;
    int  last_beat_cyc = -1;
    int  refresh_cyc = -1;
    int  w;
    bit  seen_ar = 1'b0;
    bit  rst_hit = 1'b0;
    logic [CL-1:0] got;
    logic [CL-1:0] exp;

    icache_miss  = 1'b1;
    icache_raddr = v.addr;
    sb_q.push_back(exp_line(v.base));
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      icache_raddr = $urandom;
      arready = 1'b0;
      rvalid  = 1'b0;
      rresp   = 2'b11;
      rlast   = 1'b0;
      rdata   = $urandom;
      rid     = 4'($urandom);
      if (cyc == 1) check($sformatf("v%0d arvalid_c1", idx), arvalid, 1'b1);
      if (arvalid) begin
        check($sformatf("v%0d ar_fields", idx), {araddr, arlen, arburst, arsize, arid},
              {exp_araddr(v.addr), 8'd15, EXP_BURST, 3'b010, 4'd0});
        seen_ar = 1'b1;
        if (ar_left > 0) ar_left--;
        else arready = 1'b1;
      end
      if (rready) begin
        if (first_r < 0) first_r = cyc;
        if (beats == v.rst_beat) begin
          reset   = 1'b1;
          rst_hit = 1'b1;
          break;
        end
        if (beats < WORDS && (!v.gap || ((cyc - first_r) % 2 == 0))) begin
          w       = (start_of(v.addr) + beats) % WORDS;
          rvalid  = 1'b1;
          rdata   = v.base + 32'(w);
          rresp   = (beats == v.err_beat) ? 2'b10 : 2'b00;
          rlast   = (beats == WORDS - 1);
          if (beats == v.err_beat) err_exp = 1'b1;
          beats++;
          last_beat_cyc = cyc;
        end
      end
      if (icache_refresh) begin
        refresh_cyc = cyc;
        got = icache_cacheline_new;
        break;
      end
    end

    if (rst_hit) begin
      @(negedge clk);
      check($sformatf("v%0d rst_outputs", idx), {rready, arvalid, icache_refresh, refill_err}, 4'b0);
      check($sformatf("v%0d rst_line", idx), icache_cacheline_new, '0);
      reset       = 1'b0;
      icache_miss = 1'b0;
      err_exp     = 1'b0;
      void'(sb_q.pop_front());
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check($sformatf("v%0d rst_no_refresh", idx), icache_refresh, 1'b0);
      end
      return;
    end

    if (refresh_cyc < 0) begin
      check($sformatf("v%0d refresh_timeout", idx), 1'b0, 1'b1);
      return;
    end
    check($sformatf("v%0d ar_seen", idx), seen_ar, 1'b1);
    exp = sb_q.pop_front();
    $display("refill %0d addr=0x%08h araddr=0x%08h refresh_cyc=%0d err=%0b", idx, v.addr, araddr, refresh_cyc, refill_err);
    check($sformatf("v%0d line", idx), got, exp);
    check($sformatf("v%0d refresh_after_last_beat", idx), refresh_cyc, last_beat_cyc + 1);
    if (v.exp_cyc > 0) check($sformatf("v%0d refresh_cyc", idx), refresh_cyc, v.exp_cyc);
    check($sformatf("v%0d refill_err", idx), refill_err, err_exp);

    if (v.hold) icache_raddr = v.next_addr;
    else icache_miss = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d refresh_one_cycle", idx), icache_refresh, 1'b0);
    check($sformatf("v%0d line_stable", idx), icache_cacheline_new, exp);
    check($sformatf("v%0d cool_no_ar", idx), arvalid, 1'b0);
    @(negedge clk);
    check($sformatf("v%0d idle_no_ar", idx), arvalid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{32'h1FC0_0044, 32'h0000_00A0, 0, 1'b0, -1, -1, 1'b0, 32'h0, 18};
    vecs[1] = '{32'h1FC0_0044, 32'h0000_0100, 0, 1'b0, -1, -1, 1'b1, 32'h2000_1238, 18};
    vecs[2] = '{32'h2000_1238, 32'h0000_0200, 0, 1'b0, -1, -1, 1'b0, 32'h0, 18};
    vecs[3] = '{32'h0000_0FFC, 32'h1234_0000, 5, 1'b1, -1, -1, 1'b0, 32'h0, 38};
    vecs[4] = '{32'h8000_0020, 32'h0000_0300, 0, 1'b0, 7, -1, 1'b0, 32'h0, 18};
    vecs[5] = '{32'h8000_0040, 32'h0000_0400, 0, 1'b0, -1, -1, 1'b0, 32'h0, 18};
    vecs[6] = '{32'h4000_0010, 32'h0000_0500, 0, 1'b0, -1, 9, 1'b0, 32'h0, 0};
    vecs[7] = '{32'h4000_0010, 32'h0000_0600, 0, 1'b0, -1, -1, 1'b0, 32'h0, 18};

    reset        = 1'b1;
    icache_miss  = 1'b0;
    icache_raddr = 32'hDEAD_BEEF;
    arready      = 1'b0;
    rid          = '0;
    rdata        = '0;
    rresp        = '0;
    rlast        = 1'b0;
    rvalid       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {arvalid, rready, icache_refresh, refill_err}, 4'b0);
    check("reset_line", icache_cacheline_new, '0);
    check("reset_ar", {araddr, arlen, arburst, arsize, arid}, {32'h0, 8'h0, EXP_BURST, 3'b010, 4'd0});
    reset = 1'b0;
    @(negedge clk);
    check("idle_quiet", {arvalid, rready}, 2'b0);

    for (int i = 0; i < 8; i++) run_refill(i, vecs[i]);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
